alu_arb_ctrl: RTL and testbench

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

---
 rtl/alu_ctrl_pkg.sv | 49 ++++
 rtl/alu_datapath.sv | 91 +++++++++
 rtl/alu_arb_ctrl.sv | 150 +++++++++++++++
 tb/tb_alu_arb_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and codes for the arbitrated ALU controller and its datapath.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        UNIT_ADD   = 2'd0,
        UNIT_SHIFT = 2'd1,
        UNIT_LOGIC = 2'd2,
        UNIT_MUL   = 2'd3
    } unit_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_INC = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_DEC = 2'd3;

    localparam logic [1:0] OP_SHL = 2'd0;
    localparam logic [1:0] OP_SHR = 2'd1;
    localparam logic [1:0] OP_SAR = 2'd2;
    localparam logic [1:0] OP_SAL = 2'd3;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOR = 2'd3;

    localparam logic [1:0] OP_MUL = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic neg;
        logic err;
    } flags_t;

    localparam int unsigned CNT_W = 4;

    // Only op codes 0..3 exist, and the multiplier has a single operation.
    function automatic logic op_is_legal(input logic [1:0] unit, input logic [3:0] op);
        return (op[3:2] == 2'b00) && !((unit == UNIT_MUL) && (op[1:0] != OP_MUL));
    endfunction

endpackage

// File: rtl/alu_datapath.sv
// Purely combinational ALU: add/shift/logic/mul units with flag generation.
module alu_datapath
    import alu_ctrl_pkg::*;
(
    input  logic [1:0]  unit_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] out_o,
    output logic        carry_o,
    output logic        ovf_o,
    output logic        zero_o,
    output logic        neg_o,
    output logic        err_o
);

    logic        legal;
    logic        is_sub;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic [4:0]  shamt;
    logic [32:0] shl_w;
    logic [32:0] shr_w;
    logic [32:0] sar_w;
    logic [31:0] mul_res;
    logic [31:0] res;
    logic        carry;
    logic        ovf;

    assign legal  = op_is_legal(unit_i, op_i);
    assign is_sub = (op_i[1:0] == OP_SUB) || (op_i[1:0] == OP_DEC);
    assign b_eff  = ((op_i[1:0] == OP_INC) || (op_i[1:0] == OP_DEC)) ? 32'd1 : b_i;
    // Bit 32 of the 33-bit difference is the unsigned borrow.
    assign sum    = is_sub ? ({1'b0, a_i} - {1'b0, b_eff}) : ({1'b0, a_i} + {1'b0, b_eff});

    // The extra bit on each shifter catches the last bit shifted out; it stays 0 for shamt 0.
    assign shamt   = b_i[4:0];
    assign shl_w   = {1'b0, a_i} << shamt;
    assign shr_w   = {a_i, 1'b0} >> shamt;
    assign sar_w   = $signed({a_i, 1'b0}) >>> shamt;
    assign mul_res = a_i * b_i;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (unit_i)
            UNIT_ADD: begin
                res   = sum[31:0];
                carry = sum[32];
                if (is_sub) ovf = (a_i[31] != b_eff[31]) && (sum[31] != a_i[31]);
                else        ovf = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
            end
            UNIT_SHIFT: begin
                case (op_i[1:0])
                    OP_SHR: begin
                        res   = shr_w[32:1];
                        carry = shr_w[0];
                    end
                    OP_SAR: begin
                        res   = sar_w[32:1];
                        carry = sar_w[0];
                    end
                    default: begin
                        res   = shl_w[31:0];
                        carry = shl_w[32];
                    end
                endcase
            end
            UNIT_LOGIC: begin
                case (op_i[1:0])
                    OP_AND:  res = a_i & b_i;
                    OP_OR:   res = a_i | b_i;
                    OP_XOR:  res = a_i ^ b_i;
                    default: res = ~(a_i | b_i);
                endcase
            end
            default: res = mul_res;
        endcase
    end

    // An illegal op reports only err; even zero is held low despite the zero result.
    assign out_o   = legal ? res : '0;
    assign carry_o = legal & carry;
    assign ovf_o   = legal & ovf;
    assign zero_o  = legal & (res == '0);
    assign neg_o   = legal & res[31];
    assign err_o   = ~legal;

endmodule

// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end sequencing one ALU operation at a time
// through IDLE -> EXEC -> RESP with a single result port.
module alu_arb_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [1:0]  s0_unit,
    input  logic [3:0]  s0_op,
    input  logic [31:0] s0_a,
    input  logic [31:0] s0_b,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [1:0]  s1_unit,
    input  logic [3:0]  s1_op,
    input  logic [31:0] s1_a,
    input  logic [31:0] s1_b,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_out,
    output logic        m_id,
    output logic        m_carry,
    output logic        m_ovf,
    output logic        m_zero,
    output logic        m_neg,
    output logic        m_err,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             prio_q;
    logic [1:0]       unit_q;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             id_q;
    logic [31:0]      out_q;
    flags_t           flags_q;

    logic             any_valid;
    logic             grant_id;
    logic             accept;
    logic             capture;

    logic [31:0]      dp_out;
    flags_t           dp_flags;

    // prio_q names the requester that wins a tie; it flips to the other one on every grant.
    assign any_valid = s0_valid | s1_valid;
    assign grant_id  = (s0_valid && s1_valid) ? prio_q : s1_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)              state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == '0)         state_d = ST_RESP;
            ST_RESP: if (m_ready)             state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Readies are masked by rst so nothing looks accepted while reset is held.
    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        m_valid  = 1'b0;
        busy     = 1'b1;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy     = 1'b0;
                accept   = any_valid & ~rst;
                s0_ready = accept & ~grant_id;
                s1_ready = accept &  grant_id;
            end
            ST_EXEC: capture = (cnt_q == '0);
            ST_RESP: m_valid = 1'b1;
            default: ;
        endcase
    end

    alu_datapath u_datapath (
        .unit_i  (unit_q),
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .out_o   (dp_out),
        .carry_o (dp_flags.carry),
        .ovf_o   (dp_flags.ovf),
        .zero_o  (dp_flags.zero),
        .neg_o   (dp_flags.neg),
        .err_o   (dp_flags.err)
    );

    // NOTE: operand and result registers are reset too, so every m_* output reads 0 under reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            unit_q  <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            if (accept) begin
                unit_q <= grant_id ? s1_unit : s0_unit;
                op_q   <= grant_id ? s1_op   : s0_op;
                a_q    <= grant_id ? s1_a    : s0_a;
                b_q    <= grant_id ? s1_b    : s0_b;
                id_q   <= grant_id;
                prio_q <= ~grant_id;
                cnt_q  <= CNT_LOAD;
            end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                out_q   <= dp_out;
                flags_q <= dp_flags;
            end
        end
    end

    assign m_out   = out_q;
    assign m_id    = id_q;
    assign m_carry = flags_q.carry;
    assign m_ovf   = flags_q.ovf;
    assign m_zero  = flags_q.zero;
    assign m_neg   = flags_q.neg;
    assign m_err   = flags_q.err;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Randomized and directed bench for alu_arb_ctrl with EXEC_CYCLES 1 and 3 instances,
// checked against an arithmetic reference model and a round-robin grant model.
module tb_alu_arb_ctrl;

    typedef struct packed {
        logic [31:0] out;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        neg;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        s0_valid [2];
    logic        s1_valid [2];
    logic        s0_ready [2];
    logic        s1_ready [2];
    logic [1:0]  s0_unit  [2];
    logic [1:0]  s1_unit  [2];
    logic [3:0]  s0_op    [2];
    logic [3:0]  s1_op    [2];
    logic [31:0] s0_a     [2];
    logic [31:0] s0_b     [2];
    logic [31:0] s1_a     [2];
    logic [31:0] s1_b     [2];
    logic        m_valid  [2];
    logic        m_ready  [2];
    logic [31:0] m_out    [2];
    logic        m_id     [2];
    logic        m_carry  [2];
    logic        m_ovf    [2];
    logic        m_zero   [2];
    logic        m_neg    [2];
    logic        m_err    [2];
    logic        busy     [2];

    int n_checks = 0;
    int n_errors = 0;
    int prio [2];

    always #5 clk = ~clk;

    alu_arb_ctrl #(.EXEC_CYCLES(1)) u_dut_ec1 (
        .clk(clk), .rst(rst[0]),
        .s0_valid(s0_valid[0]), .s0_ready(s0_ready[0]), .s0_unit(s0_unit[0]), .s0_op(s0_op[0]),
        .s0_a(s0_a[0]), .s0_b(s0_b[0]),
        .s1_valid(s1_valid[0]), .s1_ready(s1_ready[0]), .s1_unit(s1_unit[0]), .s1_op(s1_op[0]),
        .s1_a(s1_a[0]), .s1_b(s1_b[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_out(m_out[0]), .m_id(m_id[0]),
        .m_carry(m_carry[0]), .m_ovf(m_ovf[0]), .m_zero(m_zero[0]), .m_neg(m_neg[0]),
        .m_err(m_err[0]), .busy(busy[0])
    );

    alu_arb_ctrl #(.EXEC_CYCLES(3)) u_dut_ec3 (
        .clk(clk), .rst(rst[1]),
        .s0_valid(s0_valid[1]), .s0_ready(s0_ready[1]), .s0_unit(s0_unit[1]), .s0_op(s0_op[1]),
        .s0_a(s0_a[1]), .s0_b(s0_b[1]),
        .s1_valid(s1_valid[1]), .s1_ready(s1_ready[1]), .s1_unit(s1_unit[1]), .s1_op(s1_op[1]),
        .s1_a(s1_a[1]), .s1_b(s1_b[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_out(m_out[1]), .m_id(m_id[1]),
        .m_carry(m_carry[1]), .m_ovf(m_ovf[1]), .m_zero(m_zero[1]), .m_neg(m_neg[1]),
        .m_err(m_err[1]), .busy(busy[1])
    );

    function automatic int exec_cycles(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU: plain 64-bit arithmetic on the operand values.
    function automatic res_t ref_alu(input logic [1:0] unit, input logic [3:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
        res_t               r;
        longint             sa, sb, sr;
        longint unsigned    ua, ub, ur;
        logic signed [31:0] a_s;
        int                 sh;
        r = '0;
        if (op > 4'd3 || (unit == 2'd3 && op != 4'd0)) begin
            r.err = 1'b1;
            return r;
        end
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = 64'(a);
        ub  = 64'(b);
        a_s = a;
        sh  = int'(b[4:0]);
        case (unit)
            2'd0: begin
                if (op == 4'd1 || op == 4'd3) begin
                    sb = 1;
                    ub = 1;
                end
                if (op < 4'd2) begin
                    sr      = sa + sb;
                    ur      = ua + ub;
                    r.carry = ur[32];
                end else begin
                    sr      = sa - sb;
                    ur      = ua - ub;
                    r.carry = (ua < ub);
                end
                r.out = ur[31:0];
                r.ovf = (sr != longint'($signed(r.out)));
            end
            2'd1: begin
                if (op == 4'd1) begin
                    r.out   = a >> sh;
                    r.carry = (sh != 0) && a[sh-1];
                end else if (op == 4'd2) begin
                    r.out   = a_s >>> sh;
                    r.carry = (sh != 0) && a[sh-1];
                end else begin
                    r.out   = a << sh;
                    r.carry = (sh != 0) && a[32-sh];
                end
            end
            2'd2: begin
                case (op)
                    4'd0:    r.out = a & b;
                    4'd1:    r.out = a | b;
                    4'd2:    r.out = a ^ b;
                    default: r.out = ~(a | b);
                endcase
            end
            default: begin
                sr    = sa * sb;
                r.out = sr[31:0];
            end
        endcase
        r.zero = (r.out == 32'd0);
        r.neg  = r.out[31];
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int k, input int r, input logic [1:0] unit, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            s0_unit[k] = unit; s0_op[k] = op; s0_a[k] = a; s0_b[k] = b; s0_valid[k] = 1'b1;
        end else begin
            s1_unit[k] = unit; s1_op[k] = op; s1_a[k] = a; s1_b[k] = b; s1_valid[k] = 1'b1;
        end
    endtask

    task automatic set_rand_req(input int k, input int r);
        logic [1:0] u;
        logic [3:0] op;
        u = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
        else if (u == 2'd3)            op = 4'd0;
        else                           op = 4'($urandom_range(0, 3));
        set_req(k, r, u, op, rand_word(), rand_word());
    endtask

    // One full transaction on instance k using whatever requests are currently driven.
    // The accept cycle (ready seen) is cycle 0; m_valid is expected in cycle EXEC_CYCLES+1.
    task automatic round(input int k, input int hold, output int g, output logic [31:0] o_out,
                         output logic [4:0] o_fl, output logic o_id);
        res_t        e;
        int          cyc;
        logic [37:0] snap;
        #1;
        if (s0_valid[k] && s1_valid[k]) g = prio[k];
        else                            g = s1_valid[k] ? 1 : 0;
        if (g == 0) e = ref_alu(s0_unit[k], s0_op[k], s0_a[k], s0_b[k]);
        else        e = ref_alu(s1_unit[k], s1_op[k], s1_a[k], s1_b[k]);
        cyc = 0;
        while (!(s0_ready[k] || s1_ready[k]) && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("grant_s0", s0_ready[k], g == 0);
        check("grant_s1", s1_ready[k], g == 1);
        prio[k] = 1 - g;
        @(negedge clk);
        if (g == 0) s0_valid[k] = 1'b0;
        else        s1_valid[k] = 1'b0;
        #1;
        cyc = 1;
        while (!m_valid[k] && cyc < 40) begin
            check("busy_exec", busy[k], 1);
            check("ready_exec", {s0_ready[k], s1_ready[k]}, 0);
            @(negedge clk); #1;
            cyc++;
        end
        check("latency", cyc, exec_cycles(k) + 1);
        snap = {m_out[k], m_id[k], m_carry[k], m_ovf[k], m_zero[k], m_neg[k], m_err[k]};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check("resp_hold", {m_out[k], m_id[k], m_carry[k], m_ovf[k], m_zero[k], m_neg[k], m_err[k]}, snap);
            check("resp_valid", m_valid[k], 1);
            check("resp_busy", busy[k], 1);
            check("resp_ready", {s0_ready[k], s1_ready[k]}, 0);
        end
        check("m_out", m_out[k], e.out);
        check("m_id", m_id[k], g);
        check("m_carry", m_carry[k], e.carry);
        check("m_ovf", m_ovf[k], e.ovf);
        check("m_zero", m_zero[k], e.zero);
        check("m_neg", m_neg[k], e.neg);
        check("m_err", m_err[k], e.err);
        o_out = m_out[k];
        o_fl  = {m_carry[k], m_ovf[k], m_zero[k], m_neg[k], m_err[k]};
        o_id  = m_id[k];
        m_ready[k] = 1'b1;
        @(negedge clk);
        m_ready[k] = 1'b0;
        #1;
        check("valid_drop", m_valid[k], 0);
    endtask

    // Single directed op from requester 0 with literal expectations ({carry,ovf,zero,neg,err}).
    task automatic one_op(input int k, input string tag, input logic [1:0] u, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic [4:0] exp_fl, input int hold);
        int          g;
        logic [31:0] o;
        logic [4:0]  fl;
        logic        id;
        set_req(k, 0, u, op, a, b);
        round(k, hold, g, o, fl, id);
        check({tag, "_out"}, o, exp_out);
        check({tag, "_flags"}, fl, exp_fl);
        check({tag, "_id"}, id, 0);
    endtask

    task automatic rand_rounds(input int k, input int n);
        int          g;
        logic [31:0] o;
        logic [4:0]  fl;
        logic        id;
        for (int i = 0; i < n; i++) begin
            if (!s0_valid[k] && $urandom_range(0, 9) < 6) set_rand_req(k, 0);
            if (!s1_valid[k] && $urandom_range(0, 9) < 6) set_rand_req(k, 1);
            if (!s0_valid[k] && !s1_valid[k]) set_rand_req(k, $urandom_range(0, 1));
            round(k, $urandom_range(0, 3), g, o, fl, id);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        int          cnt0;
        int          cnt1;
        int          cyc;
        logic [31:0] o;
        logic [4:0]  fl;
        logic        id;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; m_ready[k] = 1'b0;
            s0_unit[k] = '0; s0_op[k] = '0; s0_a[k] = '0; s0_b[k] = '0;
            s1_unit[k] = '0; s1_op[k] = '0; s1_a[k] = '0; s1_b[k] = '0;
            s0_valid[k] = 1'b1; s1_valid[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", {s0_ready[k], s1_ready[k]}, 0);
            check("rst_valid", m_valid[k], 0);
            check("rst_busy", busy[k], 0);
            check("rst_outs", {m_out[k], m_id[k], m_carry[k], m_ovf[k], m_zero[k], m_neg[k], m_err[k]}, 0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0; s0_valid[k] = 1'b0; s1_valid[k] = 1'b0; prio[k] = 0;
        end

        // Both requesters busy for three ops each: grants alternate starting with s0.
        set_req(0, 0, 2'd0, 4'd0, 32'd1, 32'd2);
        set_req(0, 1, 2'd2, 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            round(0, 0, g, o, fl, id);
            check("alt_id", id, i % 2);
            if (g == 0) begin
                cnt0++;
                if (cnt0 < 3) set_req(0, 0, 2'd3, 4'd0, 32'(cnt0 * 1000), 32'hFFFF_FFF9);
            end else begin
                cnt1++;
                if (cnt1 < 3) set_req(0, 1, 2'd1, 4'd2, 32'h8000_0F00, 32'(cnt1 + 3));
            end
        end

        one_op(0, "add_ovf", 2'd0, 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01010, 0);
        one_op(0, "sub_eq",  2'd0, 4'd2, 32'd5, 32'd5, 32'h0000_0000, 5'b00100, 1);
        one_op(0, "sub_neg", 2'd0, 4'd2, 32'd3, 32'd5, 32'hFFFF_FFFE, 5'b10010, 0);
        one_op(0, "mul_neg", 2'd3, 4'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 5'b00010, 2);
        one_op(0, "shr_1",   2'd1, 4'd1, 32'h8000_0001, 32'd1, 32'h4000_0000, 5'b10000, 0);
        one_op(0, "sar_4",   2'd1, 4'd2, 32'h8000_0000, 32'd4, 32'hF800_0000, 5'b00010, 0);
        one_op(0, "shl_0",   2'd1, 4'd0, 32'h1234_5678, 32'd0, 32'h1234_5678, 5'b00000, 0);
        one_op(0, "dec_0",   2'd0, 4'd3, 32'd0, 32'd99, 32'hFFFF_FFFF, 5'b10010, 0);

        rand_rounds(0, 40);

        // EXEC_CYCLES=3: long stall in RESP while the other requester waits.
        set_req(1, 0, 2'd2, 4'd3, 32'h0F0F_0000, 32'h0000_00FF);
        set_req(1, 1, 2'd3, 4'd1, 32'd6, 32'd7);
        round(1, 10, g, o, fl, id);
        check("stall_id", id, 0);
        check("stall_out", o, 32'hF0F0_FF00);
        round(1, 0, g, o, fl, id);
        check("illegal_out", o, 32'd0);
        check("illegal_flags", fl, 5'b00001);
        check("illegal_id", id, 1);

        // Reset in the middle of EXEC drops the op and restores s0 priority.
        set_req(1, 0, 2'd0, 4'd0, 32'd10, 32'd20);
        #1;
        cyc = 0;
        while (!s0_ready[1] && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("rst_pre_grant", s0_ready[1], 1);
        @(negedge clk);
        s0_valid[1] = 1'b0;
        @(negedge clk);
        check("rst_pre_busy", busy[1], 1);
        rst[1] = 1'b1;
        set_req(1, 0, 2'd2, 4'd0, 32'hFFFF_0000, 32'h00FF_FF00);
        set_req(1, 1, 2'd2, 4'd1, 32'h0000_000F, 32'h0000_00F0);
        #1;
        check("rst_mid_valid", m_valid[1], 0);
        check("rst_mid_busy", busy[1], 0);
        check("rst_mid_ready", {s0_ready[1], s1_ready[1]}, 0);
        @(negedge clk);
        rst[1] = 1'b0;
        s0_valid[1] = 1'b0;
        s1_valid[1] = 1'b0;
        prio[1] = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            check("rst_no_resp", {m_valid[1], busy[1]}, 0);
        end
        s0_valid[1] = 1'b1;
        s1_valid[1] = 1'b1;
        round(1, 0, g, o, fl, id);
        check("rst_regrant_id", id, 0);
        check("rst_regrant_out", o, 32'h00FF_0000);

        rand_rounds(1, 30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
